// File: rtl/uart_bus_slave_if.sv
// uart_bus_slave_if: CPU data-bus port set plus the uart_rx/uart_tx handshake lines of uart_bus_slave.
// slave modport is the UART responder side, master is the CPU/UART-core side.
//   rd, wr, addr, wdata -> CPU load/store strobes, byte address and store data (MEM stage)
//   rdata, irqout       <- combinational load data and level interrupt
//   rx_dv, rx_byte      -> received-byte strobe and value from uart_rx
//   tx_en, tx_byte      <- start strobe and byte to uart_tx
//   tx_active           -> uart_tx busy flag
interface uart_bus_slave_if;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irqout;
  logic        rx_dv;
  logic [7:0]  rx_byte;
  logic        tx_en;
  logic [7:0]  tx_byte;
  logic        tx_active;
  modport slave (
    input  rd, wr, addr, wdata, rx_dv, rx_byte, tx_active,
    output rdata, irqout, tx_en, tx_byte
  );
  modport master (
    output rd, wr, addr, wdata, rx_dv, rx_byte, tx_active,
    input  rdata, irqout, tx_en, tx_byte
  );
endinterface

// File: rtl/uart_bus_slave.sv
// uart_bus_slave: memory-mapped UART responder with RX/TX FIFOs, TX handshake FSM and RX-pending interrupt.
// Ports: clk (rising-edge clock), reset (async active-high), bus (uart_bus_slave_if.slave: CPU bus + UART handshake).
// Registers at addr[3:2]: 0 RXDATA (read pops), 1 TXDATA (write pushes), 2 STATUS (bits 5/6 W1C), 3 CTRL.
// Define UART_SLAVE_IRQ_EN to implement CTRL.rx_ie and the registered interrupt; otherwise irqout is 0.
module uart_bus_slave #(
  parameter logic [31:0] BASE_ADDR = 32'h40000020,
  parameter int          DEPTH     = 8
) (
  input logic             clk,
  input logic             reset,
  uart_bus_slave_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, LOAD, WAIT_ACT, WAIT_DONE} state_t;
  state_t      r_state, w_next;
  logic [7:0]  r_rx_mem [DEPTH];
  logic [7:0]  r_tx_mem [DEPTH];
  logic [AW:0] r_rx_wp, r_rx_rp, r_tx_wp, r_tx_rp;
  logic [1:0]  r_act_cnt;
  logic [7:0]  r_tx_byte;
  logic        r_rx_ovf, r_tx_drop;
  logic        w_sel;
  logic [1:0]  w_off;
  logic        w_rx_empty, w_rx_full, w_tx_empty, w_tx_full;
  logic        w_rx_pop, w_rx_push, w_tx_pop, w_tx_store, w_tx_push, w_stat_wr;
  logic        w_rx_ie;
  logic [31:0] w_status;

  assign w_sel      = bus.addr[31:4] == BASE_ADDR[31:4];
  assign w_off      = bus.addr[3:2];
  assign w_rx_empty = r_rx_wp == r_rx_rp;
  assign w_rx_full  = (r_rx_wp[AW] != r_rx_rp[AW]) && (r_rx_wp[AW-1:0] == r_rx_rp[AW-1:0]);
  assign w_tx_empty = r_tx_wp == r_tx_rp;
  assign w_tx_full  = (r_tx_wp[AW] != r_tx_rp[AW]) && (r_tx_wp[AW-1:0] == r_tx_rp[AW-1:0]);

  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands at the tail.
  assign w_rx_pop   = w_sel && bus.rd && w_off == 2'd0 && !w_rx_empty;
  assign w_rx_push  = bus.rx_dv && (!w_rx_full || w_rx_pop);
  assign w_tx_pop   = r_state == IDLE && !w_tx_empty;
  assign w_tx_store = w_sel && bus.wr && w_off == 2'd1;
  assign w_tx_push  = w_tx_store && (!w_tx_full || w_tx_pop);
  assign w_stat_wr  = w_sel && bus.wr && w_off == 2'd2;

  assign w_status = {25'd0, r_tx_drop, r_rx_ovf, r_state != IDLE, w_tx_empty, w_tx_full, w_rx_full, !w_rx_empty};

  assign bus.rdata = !(w_sel && bus.rd) ? 32'd0 :
                     w_off == 2'd0      ? {24'd0, w_rx_empty ? 8'd0 : r_rx_mem[r_rx_rp[AW-1:0]]} :
                     w_off == 2'd2      ? w_status :
                     w_off == 2'd3      ? {31'd0, w_rx_ie} : 32'd0;

  always_ff @(posedge clk) begin
    if (w_rx_push) r_rx_mem[r_rx_wp[AW-1:0]] <= bus.rx_byte;
    if (w_tx_push) r_tx_mem[r_tx_wp[AW-1:0]] <= bus.wdata[7:0];
  end

  // Sticky error flags: a new error in the same cycle as its W1C keeps the flag set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_wp   <= '0;
      r_rx_rp   <= '0;
      r_tx_wp   <= '0;
      r_tx_rp   <= '0;
      r_tx_byte <= '0;
      r_rx_ovf  <= 1'b0;
      r_tx_drop <= 1'b0;
    end else begin
      if (w_rx_push) r_rx_wp <= r_rx_wp + 1'b1;
      if (w_rx_pop) r_rx_rp <= r_rx_rp + 1'b1;
      if (w_tx_push) r_tx_wp <= r_tx_wp + 1'b1;
      if (w_tx_pop) begin
        r_tx_rp   <= r_tx_rp + 1'b1;
        r_tx_byte <= r_tx_mem[r_tx_rp[AW-1:0]];
      end
      r_rx_ovf  <= (bus.rx_dv && !w_rx_push) || (r_rx_ovf && !(w_stat_wr && bus.wdata[5]));
      r_tx_drop <= (w_tx_store && !w_tx_push) || (r_tx_drop && !(w_stat_wr && bus.wdata[6]));
    end
  end

  // r_act_cnt counts WAIT_ACT cycles so a missed tx_active rise cannot stall the FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_act_cnt <= '0;
    end else begin
      r_state   <= w_next;
      r_act_cnt <= r_state == WAIT_ACT ? r_act_cnt + 1'b1 : 2'd0;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      if (!w_tx_empty) w_next = LOAD;
      LOAD:      w_next = WAIT_ACT;
      WAIT_ACT:  if (bus.tx_active || r_act_cnt == 2'd3) w_next = WAIT_DONE;
      WAIT_DONE: if (!bus.tx_active) w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  always_comb begin
    bus.tx_en   = r_state == LOAD;
    bus.tx_byte = r_tx_byte;
  end

`ifdef UART_SLAVE_IRQ_EN
  logic r_rx_ie, r_irq;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_ie <= 1'b0;
      r_irq   <= 1'b0;
    end else begin
      if (w_sel && bus.wr && w_off == 2'd3) r_rx_ie <= bus.wdata[0];
      r_irq <= r_rx_ie && !w_rx_empty;
    end
  end
  assign w_rx_ie    = r_rx_ie;
  assign bus.irqout = r_irq;
`else
  assign w_rx_ie    = 1'b0;
  assign bus.irqout = 1'b0;
`endif
endmodule

// File: tb/tb_uart_bus_slave.sv
// tb_uart_bus_slave: randomized and directed bench for uart_bus_slave against a queue-based behavioural model.
module tb_uart_bus_slave;
  localparam logic [31:0] BASE  = 32'h40000020;
  localparam int          DEPTH = 8;
`ifdef UART_SLAVE_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif
  localparam int PH_IDLE = 0, PH_LOAD = 1, PH_WACT = 2, PH_WDONE = 3;

  logic clk = 1'b0;
  logic reset;
  uart_bus_slave_if bus();

  uart_bus_slave #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] rxq[$];
  logic [7:0] txq[$];
  bit         m_ovf, m_drop, m_ie, m_irq;
  int         m_ph, m_wait;
  logic [7:0] m_cur;

  bit hold_act;
  int resp_delay, resp_len, pend, left;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    rxq.delete();
    txq.delete();
    m_ovf = 0; m_drop = 0; m_ie = 0; m_irq = 0;
    m_ph = PH_IDLE; m_wait = 0; m_cur = 8'h00;
  endfunction

  function automatic bit selected();
    return (bus.addr >> 4) == (BASE >> 4);
  endfunction

  function automatic logic [31:0] exp_rdata();
    int off = int'(bus.addr[3:2]);
    logic [31:0] st;
    st = {25'd0, m_drop, m_ovf, m_ph != PH_IDLE, txq.size() == 0, txq.size() == DEPTH,
          rxq.size() == DEPTH, rxq.size() > 0};
    if (!(selected() && bus.rd)) return 32'd0;
    if (off == 0) return rxq.size() > 0 ? {24'd0, rxq[0]} : 32'd0;
    if (off == 2) return st;
    if (off == 3) return {31'd0, m_ie};
    return 32'd0;
  endfunction

  // One clock edge of the specified behaviour, using the inputs present at that edge.
  function automatic void model_step();
    bit sel = selected();
    int off = int'(bus.addr[3:2]);
    bit rxpop = sel && bus.rd && off == 0 && rxq.size() > 0;
    bit store = sel && bus.wr && off == 1;
    bit wsts = sel && bus.wr && off == 2;
    bit txpop = m_ph == PH_IDLE && txq.size() > 0;
    bit rxfull = rxq.size() == DEPTH;
    bit txfull = txq.size() == DEPTH;
    m_irq = IRQ_ON && m_ie && rxq.size() > 0;
    if (wsts && bus.wdata[5]) m_ovf = 0;
    if (wsts && bus.wdata[6]) m_drop = 0;
    if (rxpop) void'(rxq.pop_front());
    if (bus.rx_dv) begin
      if (!rxfull || rxpop) rxq.push_back(bus.rx_byte);
      else m_ovf = 1;
    end
    if (txpop) m_cur = txq.pop_front();
    if (store) begin
      if (!txfull || txpop) txq.push_back(bus.wdata[7:0]);
      else m_drop = 1;
    end
    if (IRQ_ON && sel && bus.wr && off == 3) m_ie = bus.wdata[0];
    if (m_ph == PH_IDLE) begin
      if (txpop) m_ph = PH_LOAD;
    end else if (m_ph == PH_LOAD) begin
      m_ph = PH_WACT;
      m_wait = 0;
    end else if (m_ph == PH_WACT) begin
      m_wait++;
      if (bus.tx_active || m_wait == 4) m_ph = PH_WDONE;
    end else if (!bus.tx_active) m_ph = PH_IDLE;
  endfunction

  always @(negedge clk) begin
    chk("rdata", bus.rdata, exp_rdata());
    chk("tx_en", {31'd0, bus.tx_en}, {31'd0, m_ph == PH_LOAD});
    chk("tx_byte", {24'd0, bus.tx_byte}, {24'd0, m_cur});
    chk("irqout", {31'd0, bus.irqout}, {31'd0, m_irq});
  end

  // Advance one edge; also plays uart_tx by raising tx_active after each start strobe.
  task automatic tick();
    bit launch;
    launch = m_ph == PH_LOAD;
    @(posedge clk);
    if (!reset) model_step();
    #1;
    if (hold_act) bus.tx_active = 1'b1;
    else begin
      if (launch) pend = resp_delay;
      if (pend == 0) begin
        bus.tx_active = 1'b1;
        left = resp_len;
        pend = -1;
      end else if (pend > 0) pend--;
      else if (left > 0) begin
        left--;
        if (left == 0) bus.tx_active = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    hold_act = 0; pend = -1; left = 0;
    bus.tx_active = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic bus_wr(input int off, input logic [31:0] d);
    bus.wr = 1'b1;
    bus.addr = BASE + 32'(off * 4);
    bus.wdata = d;
    tick();
    bus.wr = 1'b0;
  endtask

  task automatic bus_rd(input int off, output logic [31:0] d);
    bus.rd = 1'b1;
    bus.addr = BASE + 32'(off * 4);
    #1 d = bus.rdata;
    tick();
    bus.rd = 1'b0;
  endtask

  task automatic rx_push(input logic [7:0] b);
    bus.rx_dv = 1'b1;
    bus.rx_byte = b;
    tick();
    bus.rx_dv = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d;
    int n;
    bus.rd = 0; bus.wr = 0; bus.addr = 0; bus.wdata = 0;
    bus.rx_dv = 0; bus.rx_byte = 0; bus.tx_active = 0;
    reset = 0; hold_act = 0; resp_delay = 0; resp_len = 20; pend = -1; left = 0;
    do_reset();
    chk("rst_rdata", bus.rdata, 32'd0);
    chk("rst_tx_en", {31'd0, bus.tx_en}, 32'd0);
    chk("rst_tx_byte", {24'd0, bus.tx_byte}, 32'd0);
    chk("rst_irqout", {31'd0, bus.irqout}, 32'd0);
    bus_rd(2, d);
    chk("rst_status", d, 32'h08);

    for (int i = 1; i <= 9; i++) rx_push(8'(i));
    bus_rd(2, d);
    chk("rx_full_ovf_status", d, 32'h2B);
    for (int i = 1; i <= 8; i++) begin
      bus_rd(0, d);
      chk("rx_pop_data", d, 32'(i));
    end
    bus_rd(2, d);
    chk("rx_drained_status", d, 32'h28);
    bus_wr(2, 32'h20);
    bus_rd(2, d);
    chk("w1c_status", d, 32'h08);

    for (int i = 1; i <= 8; i++) rx_push(8'(i));
    bus.rd = 1'b1; bus.addr = BASE; bus.rx_dv = 1'b1; bus.rx_byte = 8'hAA;
    #1 d = bus.rdata;
    tick();
    bus.rd = 1'b0; bus.rx_dv = 1'b0;
    chk("full_pushpop_data", d, 32'h01);
    bus_rd(2, d);
    chk("full_pushpop_status", d, 32'h0B);
    for (int i = 2; i <= 8; i++) begin
      bus_rd(0, d);
      chk("full_pushpop_drain", d, 32'(i));
    end
    bus_rd(0, d);
    chk("full_pushpop_tail", d, 32'hAA);

    resp_delay = 0; resp_len = 20;
    bus_wr(1, 32'h55);
    bus_wr(1, 32'hC3);
    n = 0;
    while (n < 50 && !bus.tx_en) begin tick(); n++; end
    chk("tx1_seen", {31'd0, bus.tx_en}, 32'd1);
    chk("tx1_byte", {24'd0, bus.tx_byte}, 32'h55);
    tick();
    chk("tx1_one_cycle", {31'd0, bus.tx_en}, 32'd0);
    n = 1;
    while (n < 100 && !bus.tx_en) begin tick(); n++; end
    chk("tx2_byte", {24'd0, bus.tx_byte}, 32'hC3);
    chk("tx2_spacing", 32'(n), 32'd23);
    repeat (30) tick();

    hold_act = 1; bus.tx_active = 1'b1;
    for (int i = 1; i <= 10; i++) bus_wr(1, 32'(i));
    bus_rd(2, d);
    chk("tx_drop_status", d, 32'h54);
    chk("tx_drop_head", {24'd0, bus.tx_byte}, 32'h01);
    do_reset();
    chk("midtx_rst_tx_en", {31'd0, bus.tx_en}, 32'd0);
    chk("midtx_rst_irqout", {31'd0, bus.irqout}, 32'd0);
    bus_rd(2, d);
    chk("midtx_rst_status", d, 32'h08);

`ifdef UART_SLAVE_IRQ_EN
    bus_wr(3, 32'h1);
    bus_rd(3, d);
    chk("ctrl_readback", d, 32'h1);
    rx_push(8'h7E);
    chk("irq_low_after_dv", {31'd0, bus.irqout}, 32'd0);
    tick();
    chk("irq_rise", {31'd0, bus.irqout}, 32'd1);
    bus_rd(0, d);
    chk("irq_data", d, 32'h7E);
    chk("irq_held", {31'd0, bus.irqout}, 32'd1);
    tick();
    chk("irq_fall", {31'd0, bus.irqout}, 32'd0);
    bus_wr(3, 32'h0);
`else
    bus_wr(3, 32'h1);
    bus_rd(3, d);
    chk("ctrl_absent", d, 32'h0);
`endif

    for (int c = 0; c < 4000; c++) begin
      bit rd_heavy = ((c / 250) % 2) == 0;
      int sel_kind = int'($urandom_range(0, 19));
      if (c == 2000) do_reset();
      bus.rd = $urandom_range(0, 99) < (rd_heavy ? 45 : 8);
      bus.wr = $urandom_range(0, 99) < 30;
      bus.addr = sel_kind == 0 ? $urandom : sel_kind == 1 ? BASE + 32'h10 :
                 BASE + 32'($urandom_range(0, 15));
      bus.wdata = $urandom_range(0, 3) == 0 ? $urandom : {24'd0, 8'($urandom)};
      bus.rx_dv = $urandom_range(0, 99) < 35;
      bus.rx_byte = 8'($urandom);
      resp_delay = int'($urandom_range(0, 6)) - 1;
      resp_len = int'($urandom_range(1, 6));
      tick();
    end
    bus.rd = 0; bus.wr = 0; bus.rx_dv = 0;
    repeat (20) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
